multi_timer: RTL and testbench
==============================

// Module: multi_timer
// PURPOSE
//   N-channel programmable tick generator; successor to the single-channel fixed-period timer.
//   Per channel: run-time period, periodic or one-shot mode, immediate or delayed first tick.
//   Optional global synchronous restart for phase-aligned ticks.
//   Feeds UART baud, debounce and LED-blink logic from one shared block.
// PARAMETERS
//   N_CH            4    number of independent channels (>=1)
//   CNT_W           16   period/counter width; max period 2^CNT_W-1
//   RESET_PERIOD    1    period loaded into every channel at reset
//   RESET_DELAYED   0    reset value of per-channel delayed-first-tick bit
// PORTS
//   clk            in   1          single clock, rising edge
//   reset_n        in   1          asynchronous, active-low reset
//   enable         in   N_CH       per-channel run request, level-sensitive
//   sync_restart   in   1          one-cycle pulse: restart every enabled channel
//   cfg_we         in   1          config write strobe
//   cfg_ch         in   CH_W       target channel; CH_W = max(1,$clog2(N_CH))
//   cfg_period     in   CNT_W      period P in clk cycles
//   cfg_oneshot    in   1          1 = single tick per enable
//   cfg_delayed    in   1          1 = first tick after P cycles, 0 = immediately
//   tick           out  N_CH       registered one-cycle tick pulses
//   running        out  N_CH       channel state == RUN
//   done           out  N_CH       one-shot channel has fired, waiting for enable low
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - All regs at reset values: tick=0, running=0, done=0, state=IDLE, cnt=0.
//   - shadow/active period = RESET_PERIOD, oneshot=0, delayed=RESET_DELAYED.
//   Config:
//   - cfg_we writes shadow period/oneshot/delayed of channel cfg_ch at the clock edge.
//   - Writes with cfg_ch >= N_CH are ignored.
//   - Active period loads from shadow in IDLE and at each counter wrap (never mid-period).
//   - oneshot/delayed are latched only on IDLE->RUN or restart.
//   - Effective period Pe = max(P,1); P=0 behaves as P=1.
//   Per-channel FSM, states IDLE/RUN/DONE:
//   - IDLE: cnt=0. enable=1 sampled at edge k -> RUN, cnt<=1 (mod Pe).
//   - RUN: cnt<=(cnt==Pe-1)?0:cnt+1. enable=0 -> IDLE at that edge.
//   - RUN, oneshot: after its single tick -> DONE.
//   - DONE: no ticks; enable=0 -> IDLE. Re-raising enable re-arms the channel.
//   Tick timing (tick is registered; k = edge where enable is first sampled high):
//   - immediate mode: tick high in the cycles following edges k, k+Pe, k+2Pe, ...
//   - delayed mode: tick high following edges k+Pe, k+2Pe, ...
//   - Pe=1: tick is continuously high while RUN; delayed mode starts one cycle later.
//   - Enable dropping at edge j: no tick after edge j, even if one was due.
//   sync_restart:
//   - Every channel with enable=1 (RUN or DONE) behaves as if edge k occurs now.
//   - Latches mode, loads the active period, and phases all channels together.
//   - Channels with enable=0 are unaffected.
//   - Same-edge cfg_we to a restarted channel: the newly written values are used (bypass).
//   Simultaneous events:
//   - enable=0 wins over sync_restart.
//   - cfg_we never alters the current period of a running channel before its wrap.
//   - Channels are fully independent; no arbitration, no shared counter.
//   Reset mid-operation: outputs drop to 0 asynchronously; config returns to reset values.
// TESTING
//   1 ch0 P=4 immediate periodic; enable at edge 10 -> tick after edges 10,14,18; none between.
//   2 ch1 P=4 delayed periodic -> first tick after edge 14; enable low at 17 -> no tick at 18.
//   3 ch2 P=3 oneshot immediate -> single tick, done=1 from the next cycle.
//      Hold enable: no further ticks. Toggle enable low/high -> one new tick.
//   4 ch0 running P=4; write P=6 mid-period -> current period completes at 4, following gaps are 6.
//   5 ch0,ch1 P=5 running out of phase; sync_restart -> both tick the same cycle, then every 5.
//   6 P=0 and P=1 -> tick held high while RUN. cfg_ch=N_CH write -> no state change.
//      reset_n low mid-run -> tick/running/done drop to 0 immediately.

Source files
------------

// File: rtl/multi_timer_if.sv
// Configuration bus of multi_timer: one write strobe plus the per-channel settings it carries.
// Latency: a write lands in the target channel's shadow registers at the clock edge where we=1.
// Backpressure: none; every write is accepted, and writes to a nonexistent channel are dropped.
//   we       strobe, one write per cycle it is high
//   ch       target channel index
//   period   period P in clk cycles (0 behaves as 1)
//   oneshot  1 = single tick per enable
//   delayed  1 = first tick after P cycles, 0 = immediately
interface multi_timer_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
);
    logic             we;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] period;
    logic             oneshot;
    logic             delayed;

    modport master (output we, ch, period, oneshot, delayed);
    modport slave  (input  we, ch, period, oneshot, delayed);
endinterface

// File: rtl/multi_timer.sv
// N-channel programmable tick generator: per-channel period, periodic/one-shot, immediate/delayed first tick.
// Latency: tick is registered; the first immediate tick is high in the cycle after enable is sampled high.
// Backpressure: none; config writes are always accepted and ticks are pulses that need no acknowledge.
//   clk, reset_n   clock and asynchronous active-low reset
//   enable         per-channel level run request
//   sync_restart   one-cycle pulse that re-phases every enabled channel
//   cfg            configuration bus (slave side)
//   tick           one-cycle tick pulses
//   running        channel is in RUN
//   done           one-shot channel has fired and waits for enable to drop
module multi_timer #(
    parameter int          N_CH          = 4,
    parameter int          CNT_W         = 16,
    parameter int unsigned RESET_PERIOD  = 1,
    parameter bit          RESET_DELAYED = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH-1:0]   enable,
    input  logic              sync_restart,
    multi_timer_if.slave      cfg,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   running,
    output logic [N_CH-1:0]   done
);

    localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state      [N_CH];
    logic [CNT_W-1:0] cnt        [N_CH];
    logic [CNT_W-1:0] act_period [N_CH];
    logic [CNT_W-1:0] sh_period  [N_CH];
    logic [N_CH-1:0]  sh_oneshot;
    logic [N_CH-1:0]  sh_delayed;
    logic [N_CH-1:0]  oneshot_q;

    // Values a channel starts with: a same-edge config write overrides the shadow copy.
    logic [N_CH-1:0]  hit;
    logic [CNT_W-1:0] start_period [N_CH];
    logic [N_CH-1:0]  start_oneshot;
    logic [N_CH-1:0]  start_delayed;

    // A programmed period of 0 runs as period 1.
    function automatic logic [CNT_W-1:0] eff_pe(input logic [CNT_W-1:0] p);
        return (p == '0) ? CNT_W'(1) : p;
    endfunction

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            hit[i]           = cfg.we && (int'(cfg.ch) == i);
            start_period[i]  = hit[i] ? cfg.period  : sh_period[i];
            start_oneshot[i] = hit[i] ? cfg.oneshot : sh_oneshot[i];
            start_delayed[i] = hit[i] ? cfg.delayed : sh_delayed[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick       <= '0;
            running    <= '0;
            done       <= '0;
            sh_oneshot <= '0;
            sh_delayed <= {N_CH{RESET_DELAYED}};
            oneshot_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state[i]      <= IDLE;
                cnt[i]        <= '0;
                act_period[i] <= RST_P;
                sh_period[i]  <= RST_P;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (hit[i]) begin
                    sh_period[i]  <= cfg.period;
                    sh_oneshot[i] <= cfg.oneshot;
                    sh_delayed[i] <= cfg.delayed;
                end

                if (!enable[i]) begin
                    // Dropping enable wins over everything, including a due tick or a restart.
                    state[i]      <= IDLE;
                    cnt[i]        <= '0;
                    act_period[i] <= sh_period[i];
                    tick[i]       <= 1'b0;
                    running[i]    <= 1'b0;
                    done[i]       <= 1'b0;
                end else if (state[i] == IDLE || sync_restart) begin
                    // Start edge: latch mode and period, the counter is at phase 1 after this edge.
                    state[i]      <= RUN;
                    act_period[i] <= start_period[i];
                    oneshot_q[i]  <= start_oneshot[i];
                    cnt[i]        <= (eff_pe(start_period[i]) == CNT_W'(1)) ? '0 : CNT_W'(1);
                    tick[i]       <= !start_delayed[i];
                    running[i]    <= 1'b1;
                    done[i]       <= 1'b0;
                end else if (state[i] == RUN) begin
                    if (oneshot_q[i] && tick[i]) begin
                        // The single tick is on the output this cycle; park until enable drops.
                        state[i]   <= DONE;
                        cnt[i]     <= '0;
                        tick[i]    <= 1'b0;
                        running[i] <= 1'b0;
                        done[i]    <= 1'b1;
                    end else begin
                        // cnt==0 marks the start of a new period.
                        tick[i] <= (cnt[i] == '0);
                        if (cnt[i] == eff_pe(act_period[i]) - CNT_W'(1)) begin
                            // Wrap: the only point where a new period takes effect mid-run.
                            cnt[i]        <= '0;
                            act_period[i] <= sh_period[i];
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end else begin
                    tick[i]    <= 1'b0;
                    running[i] <= 1'b0;
                    done[i]    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Testbench for multi_timer: directed scenarios followed by random enable/restart/config traffic.
// Expected outputs come from a phase-arithmetic model of each channel (ticks where elapsed % Pe == 0).
// Three channels are used so that cfg_ch = 3 addresses a nonexistent channel.
module tb_multi_timer;

    localparam int N  = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  enable;
    logic          sync_restart;
    logic [N-1:0]  tick, running, done;

    multi_timer_if #(.CH_W(2), .CNT_W(CW)) cfg_bus ();

    multi_timer #(
        .N_CH(N), .CNT_W(CW), .RESET_PERIOD(1), .RESET_DELAYED(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sync_restart(sync_restart),
        .cfg(cfg_bus), .tick(tick), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state per channel.
    int   m_sp [N];
    bit   m_so [N], m_sd [N];
    bit   m_act [N], m_om [N], m_dl [N], m_fired [N];
    int   m_k [N], m_pe [N];
    logic [N-1:0] e_tick, e_run, e_done, chk_mask;

    // Random-phase scratch.
    logic [N-1:0] r_en;
    logic         r_rs, r_we, r_os, r_dl;
    logic [1:0]   r_ch;
    logic [CW-1:0] r_p;

    logic [31:0] log0, log1, log2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sp[i] = 1; m_so[i] = 0; m_sd[i] = 0;
            m_act[i] = 0; m_fired[i] = 0;
        end
        e_tick = '0; e_run = '0; e_done = '0; chk_mask = '1;
    endtask

    task automatic model_edge(input logic [N-1:0] en, input logic rs, input logic we,
                              input logic [1:0] ch, input logic [CW-1:0] p,
                              input logic os, input logic dl);
        int ph;
        bit t;
        if (we && int'(ch) < N) begin
            m_sp[ch] = int'(p); m_so[ch] = os; m_sd[ch] = dl;
            // A write to a running channel changes it at the next wrap, which this model
            // does not follow; that channel is excluded until it restarts or goes idle.
            if (en[ch] && m_act[ch] && !rs) chk_mask[ch] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (!en[i]) begin
                m_act[i] = 0; e_tick[i] = 0; e_run[i] = 0; e_done[i] = 0; chk_mask[i] = 1'b1;
            end else begin
                if (!m_act[i] || rs) begin
                    m_act[i] = 1; m_k[i] = cyc; m_pe[i] = (m_sp[i] == 0) ? 1 : m_sp[i];
                    m_om[i] = m_so[i]; m_dl[i] = m_sd[i]; m_fired[i] = 0; chk_mask[i] = 1'b1;
                end
                if (m_om[i] && m_fired[i]) begin
                    e_tick[i] = 0; e_run[i] = 0; e_done[i] = 1;
                end else begin
                    ph = cyc - m_k[i];
                    t  = ((ph % m_pe[i]) == 0) && (ph > 0 || !m_dl[i]);
                    e_tick[i] = t; e_run[i] = 1; e_done[i] = 0;
                    if (m_om[i] && t) m_fired[i] = 1;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] en, input logic rs, input logic we,
                        input logic [1:0] ch, input logic [CW-1:0] p,
                        input logic os, input logic dl);
        enable = en; sync_restart = rs;
        cfg_bus.we = we; cfg_bus.ch = ch; cfg_bus.period = p;
        cfg_bus.oneshot = os; cfg_bus.delayed = dl;
        @(posedge clk);
        cyc++;
        model_edge(en, rs, we, ch, p, os, dl);
        #1;
        check("tick",    32'(tick & chk_mask),    32'(e_tick & chk_mask));
        check("running", 32'(running & chk_mask), 32'(e_run & chk_mask));
        check("done",    32'(done & chk_mask),    32'(e_done & chk_mask));
    endtask

    task automatic run(input logic [N-1:0] en);
        step(en, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [N-1:0] en, input logic [1:0] ch, input int p,
                      input logic os, input logic dl);
        step(en, 1'b0, 1'b1, ch, CW'(p), os, dl);
    endtask

    initial begin
        reset_n = 1'b1; enable = '0; sync_restart = 1'b0;
        cfg_bus.we = 1'b0; cfg_bus.ch = '0; cfg_bus.period = '0;
        cfg_bus.oneshot = 1'b0; cfg_bus.delayed = 1'b0;
        model_reset();
        #2 reset_n = 1'b0;
        #10;
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: ch0 P=4 immediate periodic -> ticks at relative edges 0, 4, 8.
        wr(3'b000, 2'd0, 4, 1'b0, 1'b0);
        log0 = '0;
        for (int s = 0; s < 9; s++) begin
            run(3'b001);
            log0[s] = tick[0];
        end
        check("t1_tick_edges", log0, 32'h111);
        run(3'b000);

        // 2: ch1 P=4 delayed -> first tick at +4; enable low at +7 suppresses the +8 tick.
        wr(3'b000, 2'd1, 4, 1'b0, 1'b1);
        log1 = '0;
        for (int s = 0; s < 9; s++) begin
            run((s < 7) ? 3'b010 : 3'b000);
            log1[s] = tick[1];
        end
        check("t2_tick_edges", log1, 32'h010);

        // 3: ch2 P=3 one-shot immediate -> one tick, done held; re-arm gives one more.
        wr(3'b000, 2'd2, 3, 1'b1, 1'b0);
        log2 = '0;
        for (int s = 0; s < 7; s++) begin
            run(3'b100);
            log2[s] = tick[2];
        end
        check("t3_single_tick", log2, 32'h1);
        check("t3_done", 32'(done[2]), 32'd1);
        run(3'b000);
        check("t3_done_clear", 32'(done[2]), 32'd0);
        log2 = '0;
        for (int s = 0; s < 4; s++) begin
            run(3'b100);
            log2[s] = tick[2];
        end
        check("t3_rearm_tick", log2, 32'h1);
        run(3'b000);

        // 4: ch0 P=4 running, write P=6 mid-period -> ticks at 0, 4, 10, 16.
        wr(3'b000, 2'd0, 4, 1'b0, 1'b0);
        log0 = '0;
        run(3'b001);
        log0[0] = tick[0];
        wr(3'b001, 2'd0, 6, 1'b0, 1'b0);
        log0[1] = tick[0];
        for (int s = 2; s < 18; s++) begin
            run(3'b001);
            log0[s] = tick[0];
        end
        check("t4_period_change", log0, 32'h10411);
        run(3'b000);

        // 5: ch0, ch1 P=5 out of phase; sync_restart aligns them.
        wr(3'b000, 2'd0, 5, 1'b0, 1'b0);
        wr(3'b000, 2'd1, 5, 1'b0, 1'b0);
        run(3'b001);
        run(3'b001);
        for (int s = 0; s < 3; s++) run(3'b011);
        step(3'b011, 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0);
        check("t5_restart_tick", 32'(tick[1:0]), 32'h3);
        log0 = '0; log1 = '0;
        for (int s = 0; s < 10; s++) begin
            run(3'b011);
            log0[s] = tick[0];
            log1[s] = tick[1];
        end
        check("t5_ch0_phase", log0, 32'h210);
        check("t5_ch1_phase", log1, 32'h210);
        run(3'b000);

        // 6: P=0 and P=1 hold tick high; bad channel write ignored; async reset mid-run.
        wr(3'b000, 2'd2, 0, 1'b0, 1'b0);
        log2 = '0;
        for (int s = 0; s < 5; s++) begin
            run(3'b100);
            log2[s] = tick[2];
        end
        check("t6_p0_high", log2, 32'h1f);
        wr(3'b100, 2'd1, 1, 1'b0, 1'b1);
        log1 = '0;
        for (int s = 0; s < 4; s++) begin
            run(3'b110);
            log1[s] = tick[1];
        end
        check("t6_p1_delayed", log1, 32'he);
        step(3'b110, 1'b0, 1'b1, 2'd3, CW'(7), 1'b1, 1'b1);
        for (int s = 0; s < 4; s++) run(3'b110);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_tick", 32'(tick), 32'd0);
        check("t6_rst_running", 32'(running), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        model_reset();
        @(negedge clk);
        enable = '0;
        reset_n = 1'b1;
        for (int s = 0; s < 3; s++) run(3'b100);
        run(3'b000);

        // Random traffic; config writes to running channels only on restart edges.
        r_en = '0;
        for (int s = 0; s < 600; s++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) r_en[b] = ~r_en[b];
            r_rs = ($urandom_range(15) == 0);
            r_we = ($urandom_range(3) == 0);
            r_ch = 2'($urandom_range(3));
            r_p  = CW'($urandom_range(6));
            r_os = 1'($urandom_range(1));
            r_dl = 1'($urandom_range(1));
            if (r_we && int'(r_ch) < N) begin
                if (r_en[r_ch] && m_act[r_ch] && !r_rs) r_we = 1'b0;
            end
            step(r_en, r_rs, r_we, r_ch, r_p, r_os, r_dl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
